trig_window_integrator: RTL and testbench

Downstream consumer of the anti-droop corrected 16-bit sample stream. On each rising edge of the trigger it waits a programmable delay, then sums a programmable number of consecutive samples. It presents the signed sum with a one-cycle valid strobe, giving the feedback path one integrated pulse amplitude per trigger. Triggers that arrive while a window is in progress are dropped and flagged.

---
 rtl/trig_window_integrator_if.sv | 63 ++++++
 rtl/trig_window_integrator.sv | 196 +++++++++++++++++++
 tb/tb_trig_window_integrator.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_window_integrator_if.sv
// ---------------------------------------------------------------------------
// trig_window_integrator_if
//
// Groups the sample/trigger inputs and the integrated-result outputs of
// trig_window_integrator into one bundle.
//
//   trig        : asynchronous trigger level (rising edge starts a window)
//   din         : signed corrected sample
//   delay       : cycles from detected trigger edge to first summed sample
//   len         : number of samples to sum
//   flag_clr    : clears the sticky missed-trigger flag
//   sum_out     : signed window sum, held until the next result
//   sum_valid   : one-cycle strobe marking a new sum_out
//   busy        : a window is pending or in progress
//   missed_trig : sticky, a trigger edge arrived while busy
//
// Modports:
//   master : the side that produces samples/triggers and consumes results
//   slave  : the integrator itself
// ---------------------------------------------------------------------------
interface trig_window_integrator_if #(
  parameter int DIN_W   = 16,
  parameter int DELAY_W = 8,
  parameter int LEN_W   = 6,
  parameter int SUM_W   = DIN_W + LEN_W
);

  logic                      trig;
  logic signed [DIN_W-1:0]   din;
  logic        [DELAY_W-1:0] delay;
  logic        [LEN_W-1:0]   len;
  logic                      flag_clr;

  logic signed [SUM_W-1:0]   sum_out;
  logic                      sum_valid;
  logic                      busy;
  logic                      missed_trig;

  modport master (
    output trig,
    output din,
    output delay,
    output len,
    output flag_clr,
    input  sum_out,
    input  sum_valid,
    input  busy,
    input  missed_trig
  );

  modport slave (
    input  trig,
    input  din,
    input  delay,
    input  len,
    input  flag_clr,
    output sum_out,
    output sum_valid,
    output busy,
    output missed_trig
  );

endinterface

// File: rtl/trig_window_integrator.sv
// ---------------------------------------------------------------------------
// trig_window_integrator
//
// Per-trigger pulse integrator sitting after the anti-droop corrector. A
// rising edge on trig (after a two-flop synchroniser) starts a window: wait
// the latched delay, sum the latched number of consecutive samples, then
// present the signed sum with a one-cycle valid strobe. Edges arriving while a
// window is pending or in progress are dropped and flagged in missed_trig.
//
// Ports:
//   clk   : sample clock, everything on the rising edge
//   rst_n : asynchronous-assert, active-low reset
//   bus   : trig_window_integrator_if.slave
//             in : trig, din, delay, len, flag_clr
//             out: sum_out, sum_valid, busy, missed_trig
//
// Timing (k = edge at which the first synchroniser flop captures 1):
//   k+1                     : leave IDLE, busy high
//   k+2+delay .. k+1+delay+len : samples summed
//   k+2+delay+len           : sum_out updates, sum_valid high, busy low
// ---------------------------------------------------------------------------
module trig_window_integrator #(
  parameter int DIN_W   = 16,
  parameter int DELAY_W = 8,
  parameter int LEN_W   = 6,
  parameter int SUM_W   = DIN_W + LEN_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  trig_window_integrator_if.slave   bus
);

  // -------------------------------------------------------------------------
  // FSM encoding
  // -------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_INTEG = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // -------------------------------------------------------------------------
  // Trigger synchroniser and edge detect.
  // Both flops come out of reset at 1 so a trigger that is already high when
  // reset releases is not mistaken for a fresh rising edge.
  // -------------------------------------------------------------------------
  logic trig_a;
  logic trig_b;
  logic trig_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_a <= 1'b1;
      trig_b <= 1'b1;
    end else begin
      trig_a <= bus.trig;
      trig_b <= trig_a;
    end
  end

  assign trig_edge = trig_a & ~trig_b;

  // -------------------------------------------------------------------------
  // Sign extension of the incoming sample to accumulator width.
  // -------------------------------------------------------------------------
  logic [SUM_W-1:0] din_ext;

  assign din_ext[DIN_W-1:0] = bus.din;

  generate
    for (genvar gi = DIN_W; gi < SUM_W; gi++) begin : gen_sext
      assign din_ext[gi] = bus.din[DIN_W-1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]              state_reg,     state_next;
  logic [DELAY_W-1:0]      dcnt_reg,      dcnt_next;     // delay cycles left
  logic [LEN_W-1:0]        lcnt_reg,      lcnt_next;     // samples taken so far
  logic [LEN_W-1:0]        len_lat_reg,   len_lat_next;  // len captured at accept
  logic signed [SUM_W-1:0] acc_reg,       acc_next;
  logic signed [SUM_W-1:0] sum_out_reg,   sum_out_next;
  logic                    sum_valid_reg, sum_valid_next;
  logic                    missed_reg,    missed_next;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    dcnt_next      = dcnt_reg;
    lcnt_next      = lcnt_reg;
    len_lat_next   = len_lat_reg;
    acc_next       = acc_reg;
    sum_out_next   = sum_out_reg;
    sum_valid_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (trig_edge) begin
          // delay and len are only looked at here; later changes are ignored.
          // Clearing the accumulator makes a len=0 window report zero.
          len_lat_next = bus.len;
          dcnt_next    = bus.delay;
          lcnt_next    = '0;
          acc_next     = '0;
          if (bus.delay != '0) begin
            state_next = ST_DELAY;
          end else if (bus.len != '0) begin
            state_next = ST_INTEG;
          end else begin
            state_next = ST_DONE;
          end
        end
      end

      ST_DELAY: begin
        if (dcnt_reg == DELAY_W'(1)) begin
          dcnt_next  = '0;
          state_next = (len_lat_reg != '0) ? ST_INTEG : ST_DONE;
        end else begin
          dcnt_next = dcnt_reg - DELAY_W'(1);
        end
      end

      ST_INTEG: begin
        // First sample of the window loads, the rest accumulate.
        if (lcnt_reg == '0) begin
          acc_next = $signed(din_ext);
        end else begin
          acc_next = acc_reg + $signed(din_ext);
        end
        lcnt_next = lcnt_reg + LEN_W'(1);
        // len_lat_reg is non-zero whenever this state is entered.
        if (lcnt_reg == len_lat_reg - LEN_W'(1)) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        sum_out_next   = acc_reg;
        sum_valid_next = 1'b1;
        state_next     = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sticky missed-trigger flag: a new miss beats a simultaneous clear.
  always_comb begin
    missed_next = missed_reg;
    if (trig_edge && (state_reg != ST_IDLE)) begin
      missed_next = 1'b1;
    end else if (bus.flag_clr) begin
      missed_next = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      dcnt_reg      <= '0;
      lcnt_reg      <= '0;
      len_lat_reg   <= '0;
      acc_reg       <= '0;
      sum_out_reg   <= '0;
      sum_valid_reg <= 1'b0;
      missed_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dcnt_reg      <= dcnt_next;
      lcnt_reg      <= lcnt_next;
      len_lat_reg   <= len_lat_next;
      acc_reg       <= acc_next;
      sum_out_reg   <= sum_out_next;
      sum_valid_reg <= sum_valid_next;
      missed_reg    <= missed_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.sum_out     = sum_out_reg;
  assign bus.sum_valid   = sum_valid_reg;
  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.missed_trig = missed_reg;

endmodule

// File: tb/tb_trig_window_integrator.sv
// ---------------------------------------------------------------------------
// Bench for trig_window_integrator. A per-cycle reference built from input
// history (edge index arithmetic and sums over recorded samples) is compared
// against the outputs after every clock edge; directed windows additionally
// pin latency, sum and busy duration to hand-computed numbers.
// ---------------------------------------------------------------------------
module tb_trig_window_integrator;

  localparam int DIN_W   = 16;
  localparam int DELAY_W = 8;
  localparam int LEN_W   = 6;
  localparam int SUM_W   = DIN_W + LEN_W;
  localparam int HM      = 8191;   // history ring mask

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  trig_window_integrator_if #(
    .DIN_W(DIN_W), .DELAY_W(DELAY_W), .LEN_W(LEN_W), .SUM_W(SUM_W)
  ) bus ();

  trig_window_integrator #(
    .DIN_W(DIN_W), .DELAY_W(DELAY_W), .LEN_W(LEN_W), .SUM_W(SUM_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int got, input int exp_v);
    total++;
    if (got != exp_v) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp_v);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference: input history indexed by clock edge number
  // -------------------------------------------------------------------------
  int cyc = 0;
  bit trig_h [0:HM];
  int din_h  [0:HM];
  int dly_h  [0:HM];
  int len_h  [0:HM];
  bit clr_h  [0:HM];

  bit m_pending = 0;
  int m_start   = 0;
  int m_len     = 0;
  int m_v       = 0;     // edge at which the pending result appears
  int m_sum     = 0;
  bit m_valid   = 0;
  bit m_missed  = 0;

  // Observations used by the directed literal checks
  int obs_vcnt = 0;
  int obs_vcyc = 0;
  int obs_sum  = 0;
  int obs_busy = 0;

  always @(posedge clk) begin
    int n;
    bit busy_before;
    bit edge_seen;
    cyc = cyc + 1;
    n   = cyc;
    if (!rst_n) begin
      trig_h[n & HM] = 1'b1;     // synchroniser held at 1 in reset
      m_pending = 0;
      m_valid   = 0;
      m_missed  = 0;
      m_sum     = 0;
    end else begin
      trig_h[n & HM] = bus.trig;
      din_h[n & HM]  = int'($signed(bus.din));
      dly_h[n & HM]  = int'(bus.delay);
      len_h[n & HM]  = int'(bus.len);
      clr_h[n & HM]  = bus.flag_clr;
      // FSM is non-idle just before edge n iff a window is pending with its
      // result edge at or after n.
      busy_before = m_pending && (n <= m_v);
      m_valid = 0;
      if (m_pending && n == m_v) begin
        m_valid   = 1;
        m_pending = 0;
        m_sum     = 0;
        for (int i = 0; i < m_len; i++) m_sum += din_h[(m_start + i) & HM];
      end
      // Edge captured at n-1 by the first flop is acted on at edge n.
      edge_seen = trig_h[(n - 1) & HM] && !trig_h[(n - 2) & HM];
      if (edge_seen && busy_before) begin
        m_missed = 1;
      end else begin
        if (clr_h[n & HM]) m_missed = 0;
        if (edge_seen) begin
          m_pending = 1;
          m_len     = len_h[n & HM];
          m_start   = n + 1 + dly_h[n & HM];
          m_v       = m_start + m_len;
        end
      end
    end
    #1;
    chk("sum_valid", int'(bus.sum_valid), int'(m_valid));
    chk("busy", int'(bus.busy), int'(m_pending && n < m_v));
    chk("missed_trig", int'(bus.missed_trig), int'(m_missed));
    chk("sum_out", int'($signed(bus.sum_out)), m_sum);
    if (bus.sum_valid) begin
      obs_vcnt++;
      obs_vcyc = n;
      obs_sum  = int'($signed(bus.sum_out));
    end
    if (bus.busy) obs_busy++;
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers. All driving happens on the falling edge.
  // -------------------------------------------------------------------------
  int din_mode  = 0;   // 0 random, 1 constant, 2 ramp
  int cval      = 0;
  int ramp_base = 0;

  task automatic set_din();
    case (din_mode)
      1:       bus.din = 16'(cval);
      2:       bus.din = 16'(cyc + 1 - ramp_base);
      default: bus.din = 16'($urandom);
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    set_din();
  endtask

  // Return at the falling edge just before clock edge t.
  task automatic tick_to(input int t);
    while (cyc + 1 < t) tick();
  endtask

  task automatic wait_valid(input string name, input int v0, input int budget);
    int i;
    i = 0;
    while (obs_vcnt == v0 && i < budget) begin
      tick();
      i++;
    end
    if (obs_vcnt == v0) chk({name, "_timeout"}, 0, 1);
  endtask

  // One window with trig raised now; checks latency, sum and busy duration.
  task automatic window(input int d, input int l, input string name, input int exp_sum);
    int k, v0, b0;
    bus.delay = DELAY_W'(d);
    bus.len   = LEN_W'(l);
    v0 = obs_vcnt;
    b0 = obs_busy;
    bus.trig = 1'b1;
    k = cyc + 1;
    wait_valid(name, v0, d + l + 10);
    chk({name, "_latency"}, obs_vcyc - k, d + l + 2);
    chk({name, "_sum"}, obs_sum, exp_sum);
    chk({name, "_busy_cycles"}, obs_busy - b0, d + l + 1);
    bus.trig = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, v0;
    rst_n        = 1'b0;
    bus.trig     = 1'b0;
    bus.din      = '0;
    bus.delay    = '0;
    bus.len      = '0;
    bus.flag_clr = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_sum_out", int'($signed(bus.sum_out)), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_missed", int'(bus.missed_trig), 0);

    // Constant input
    din_mode = 1;
    cval     = 100;
    window(0, 4, "const", 400);

    // Ramp with a retrigger in the middle of the window
    din_mode = 2;
    k = cyc + 1;
    ramp_base = k - 10;
    set_din();
    bus.delay = 8'd3;
    bus.len   = 6'd5;
    v0 = obs_vcnt;
    bus.trig = 1'b1;
    tick_to(k + 2); bus.trig = 1'b0;
    tick_to(k + 4); bus.trig = 1'b1;
    tick_to(k + 6); bus.trig = 1'b0;
    wait_valid("ramp", v0, 20);
    chk("ramp_latency", obs_vcyc - k, 10);
    chk("ramp_sum", obs_sum, 85);
    repeat (15) tick();
    chk("ramp_one_result", obs_vcnt - v0, 1);
    chk("retrig_missed", int'(bus.missed_trig), 1);

    // Extremes
    din_mode = 1;
    cval = -32768;
    window(255, 63, "ext_neg", -2064384);
    cval = 32767;
    window(255, 63, "ext_pos", 2064321);

    // Reset in the middle of integration, trig held high through release
    din_mode = 0;
    bus.delay = 8'd5;
    bus.len   = 6'd10;
    k = cyc + 1;
    bus.trig = 1'b1;
    tick_to(k + 11);
    rst_n = 1'b0;
    #1;
    chk("arst_sum_out", int'($signed(bus.sum_out)), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_missed", int'(bus.missed_trig), 0);
    chk("arst_valid", int'(bus.sum_valid), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    v0 = obs_vcnt;
    repeat (40) tick();
    chk("arst_no_valid", obs_vcnt - v0, 0);
    chk("arst_no_window", int'(bus.busy), 0);
    bus.trig = 1'b0;
    repeat (3) tick();

    // Miss and clear in the same cycle: the miss wins; clear alone works
    bus.delay = 8'd20;
    bus.len   = 6'd5;
    k = cyc + 1;
    v0 = obs_vcnt;
    bus.trig = 1'b1;
    tick_to(k + 2); bus.trig = 1'b0;
    tick_to(k + 4); bus.trig = 1'b1;
    tick_to(k + 5); bus.flag_clr = 1'b1;
    tick_to(k + 6); bus.flag_clr = 1'b0; bus.trig = 1'b0;
    chk("set_beats_clr", int'(bus.missed_trig), 1);
    tick_to(k + 8); bus.flag_clr = 1'b1;
    tick_to(k + 9); bus.flag_clr = 1'b0;
    chk("clr_alone", int'(bus.missed_trig), 0);
    wait_valid("flagwin", v0, 40);
    chk("flagwin_latency", obs_vcyc - k, 27);
    repeat (3) tick();

    // len=0 followed by a back-to-back trigger in the valid cycle
    bus.delay = 8'd2;
    bus.len   = 6'd0;
    k = cyc + 1;
    v0 = obs_vcnt;
    bus.trig = 1'b1;
    tick_to(k + 1); bus.trig = 1'b0;
    tick_to(k + 4); bus.trig = 1'b1;
    tick_to(k + 5);
    chk("len0_valid", int'(bus.sum_valid), 1);
    chk("len0_sum", int'($signed(bus.sum_out)), 0);
    tick_to(k + 6);
    chk("b2b_busy", int'(bus.busy), 1);
    chk("b2b_no_miss", int'(bus.missed_trig), 0);
    bus.trig = 1'b0;
    tick_to(k + 10);
    chk("b2b_second_at", obs_vcyc - k, 8);
    chk("b2b_results", obs_vcnt - v0, 2);

    // Randomised run
    din_mode = 0;
    for (int i = 0; i < 2500; i++) begin
      tick();
      if ($urandom_range(0, 3) == 0) bus.delay = DELAY_W'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) bus.len   = LEN_W'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) bus.trig  = ~bus.trig;
      bus.flag_clr = ($urandom_range(0, 19) == 0);
    end
    bus.trig     = 1'b0;
    bus.flag_clr = 1'b0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
